// File: rtl/dmem_port_arbiter.sv
// Shares the single Data_Memory port between the pipeline memory stage (CPU)
// and the coefficient-loader DMA, with burst locking and bounded starvation.
module dmem_port_arbiter #(
  parameter int DATA_W       = 256,
  parameter int ADDR_W       = 16,
  parameter int MAX_BURST    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              stall_m,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_last,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              dma_busy
);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  localparam logic [7:0] LIMIT     = 8'(STARVE_LIMIT);
  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_burst_cnt, w_burst_cnt_nxt;
  logic [7:0]  r_cpu_wait, w_cpu_wait_nxt;
  logic [7:0]  r_dma_wait, w_dma_wait_nxt;
  logic        w_cpu_gnt, w_dma_gnt;
  logic        r_cpu_rvalid, r_dma_rvalid;
  logic [DATA_W-1:0] r_cpu_rdata, r_dma_rdata;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; that is what keeps synthesis from inferring latches.
  always_comb begin
    w_cpu_gnt       = 1'b0;
    w_dma_gnt       = 1'b0;
    w_state_nxt     = r_state;
    w_burst_cnt_nxt = r_burst_cnt;
    if (r_state == S_BURST && dma_req) begin
      // Locked: only a starved CPU may steal a single cycle; the lock survives.
      if (cpu_req && r_cpu_wait == LIMIT) begin
        w_cpu_gnt = 1'b1;
      end else begin
        w_dma_gnt       = 1'b1;
        w_burst_cnt_nxt = r_burst_cnt + 8'd1;
        if (dma_last || w_burst_cnt_nxt == BURST_MAX) begin
          w_state_nxt     = S_IDLE;
          w_burst_cnt_nxt = '0;
        end
      end
    end else begin
      // IDLE, or a burst abandoned by the DMA: this cycle is arbitrated fresh.
      w_state_nxt     = S_IDLE;
      w_burst_cnt_nxt = '0;
      if (dma_req && (!cpu_req || r_dma_wait == LIMIT)) begin
        w_dma_gnt = 1'b1;
        if (!dma_last && MAX_BURST > 1) begin
          w_state_nxt     = S_BURST;
          w_burst_cnt_nxt = 8'd1;
        end
      end else begin
        w_cpu_gnt = cpu_req;
      end
    end
  end

  // NOTE: grants are masked by rst so the memory port goes quiet the instant
  // reset asserts, not at the next clock edge.
  assign cpu_gnt  = rst & w_cpu_gnt;
  assign dma_gnt  = rst & w_dma_gnt;
  assign stall_m  = rst & cpu_req & ~w_cpu_gnt;
  assign dma_busy = (r_state == S_BURST);

  always_comb begin
    w_cpu_wait_nxt = '0;
    w_dma_wait_nxt = '0;
    if (cpu_req && !w_cpu_gnt)
      w_cpu_wait_nxt = (r_cpu_wait == LIMIT) ? LIMIT : r_cpu_wait + 8'd1;
    if (dma_req && !w_dma_gnt)
      w_dma_wait_nxt = (r_dma_wait == LIMIT) ? LIMIT : r_dma_wait + 8'd1;
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    if (cpu_gnt) begin
      mem_we   = cpu_we;
      mem_addr = cpu_addr;
      mem_wd   = cpu_wdata;
    end else if (dma_gnt) begin
      mem_we   = dma_we;
      mem_addr = dma_addr;
      mem_wd   = dma_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_burst_cnt  <= '0;
      r_cpu_wait   <= '0;
      r_dma_wait   <= '0;
      r_cpu_rvalid <= 1'b0;
      r_dma_rvalid <= 1'b0;
      r_cpu_rdata  <= '0;
      r_dma_rdata  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_burst_cnt  <= w_burst_cnt_nxt;
      r_cpu_wait   <= w_cpu_wait_nxt;
      r_dma_wait   <= w_dma_wait_nxt;
      r_cpu_rvalid <= cpu_gnt & ~cpu_we;
      r_dma_rvalid <= dma_gnt & ~dma_we;
      if (cpu_gnt && !cpu_we) r_cpu_rdata <= mem_rd;
      if (dma_gnt && !dma_we) r_dma_rdata <= mem_rd;
    end
  end

  assign cpu_rvalid = r_cpu_rvalid;
  assign dma_rvalid = r_dma_rvalid;
  assign cpu_rdata  = r_cpu_rdata;
  assign dma_rdata  = r_dma_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus randomized traffic,
// checked against a rule-level arbitration model and a read-data scoreboard.
module tb_dmem_port_arbiter;

  localparam int DW           = 256;
  localparam int AW           = 16;
  localparam int MAX_BURST    = 8;
  localparam int STARVE_LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0, dma_last = 1'b0;
  logic [AW-1:0] cpu_addr = '0, dma_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, dma_wdata = '0;
  logic          cpu_gnt, cpu_rvalid, stall_m, dma_gnt, dma_rvalid, mem_we, dma_busy;
  logic [DW-1:0] cpu_rdata, dma_rdata, mem_wd, mem_rd;
  logic [AW-1:0] mem_addr;

  dmem_port_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .MAX_BURST(MAX_BURST), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .stall_m(stall_m),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_last(dma_last), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .dma_busy(dma_busy)
  );

  always #5 clk = ~clk;

  // Data_Memory stand-in: combinational read, write at the clock edge.
  bit   [DW-1:0] tb_mem [1024];
  logic          pre_we = 1'b0;
  logic [9:0]    pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  assign mem_rd = tb_mem[mem_addr[9:0]];
  always @(posedge clk) begin
    if (pre_we)      tb_mem[pre_addr] <= pre_data;
    else if (mem_we) tb_mem[mem_addr[9:0]] <= mem_wd;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: arbitration rules in plain integer terms.
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  bit  m_locked;
  int  m_beats, m_cpu_wait, m_dma_wait;
  bit  m_cg, m_dg;

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  function automatic logic [DW-1:0] rand256();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  typedef struct { logic [DW-1:0] data; int due; } rd_exp_t;
  rd_exp_t cpu_q[$];
  rd_exp_t dma_q[$];

  task automatic model_reset();
    m_locked = 0; m_beats = 0; m_cpu_wait = 0; m_dma_wait = 0;
    cpu_q.delete();
    dma_q.delete();
  endtask

  // One bus cycle: drive, predict, compare, advance the model.
  task automatic cycle(input logic cr, input logic cwe, input logic [AW-1:0] ca, input logic [DW-1:0] cwd,
                       input logic dr, input logic dwe, input logic [AW-1:0] da, input logic [DW-1:0] dwd,
                       input logic dl, output logic g_c, output logic g_d, output logic busy, output logic stall);
    @(posedge clk); #1;
    cpu_req = cr; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cwd;
    dma_req = dr; dma_we = dwe; dma_addr = da; dma_wdata = dwd; dma_last = dl;
    m_cg = 0; m_dg = 0;
    if (m_locked && dr) begin
      if (cr && m_cpu_wait == STARVE_LIMIT) m_cg = 1; else m_dg = 1;
    end else if (cr && dr) begin
      if (m_dma_wait == STARVE_LIMIT) m_dg = 1; else m_cg = 1;
    end else begin
      m_cg = cr; m_dg = dr;
    end
    if (m_cg && !cwe) cpu_q.push_back('{data: ref_read(ca), due: cyc + 1});
    if (m_dg && !dwe) dma_q.push_back('{data: ref_read(da), due: cyc + 1});
    #3;
    g_c = cpu_gnt; g_d = dma_gnt; busy = dma_busy; stall = stall_m;
    check("cpu_gnt",  DW'(cpu_gnt),  DW'(m_cg));
    check("dma_gnt",  DW'(dma_gnt),  DW'(m_dg));
    check("stall_m",  DW'(stall_m),  DW'(cr && !m_cg));
    check("dma_busy", DW'(dma_busy), DW'(m_locked));
    check("mem_we",   DW'(mem_we),   DW'((m_cg && cwe) || (m_dg && dwe)));
    check("mem_addr", DW'(mem_addr), DW'(m_cg ? ca : m_dg ? da : '0));
    check("mem_wd",   mem_wd,        m_cg ? cwd : m_dg ? dwd : '0);
    if (m_cg && cwe) ref_mem[ca] = cwd;
    if (m_dg && dwe) ref_mem[da] = dwd;
    m_cpu_wait = (cr && !m_cg) ? ((m_cpu_wait < STARVE_LIMIT) ? m_cpu_wait + 1 : STARVE_LIMIT) : 0;
    m_dma_wait = (dr && !m_dg) ? ((m_dma_wait < STARVE_LIMIT) ? m_dma_wait + 1 : STARVE_LIMIT) : 0;
    if (m_dg) begin
      if (m_locked) begin
        m_beats++;
        if (dl || m_beats == MAX_BURST) begin m_locked = 0; m_beats = 0; end
      end else if (!dl && MAX_BURST > 1) begin
        m_locked = 1; m_beats = 1;
      end
    end else if (!dr) begin
      m_locked = 0; m_beats = 0;
    end
  endtask

  task automatic idle_cycle();
    logic a, b, c, d;
    cycle(0, 0, '0, '0, 0, 0, '0, '0, 0, a, b, c, d);
  endtask

  // Monitor: pops the scoreboard whenever a read result is due.
  bit      c_due, d_due;
  rd_exp_t e_c, e_d;
  always @(negedge clk) begin
    if (rst) begin
      c_due = cpu_q.size() != 0 && cpu_q[0].due == cyc;
      d_due = dma_q.size() != 0 && dma_q[0].due == cyc;
      check("cpu_rvalid", DW'(cpu_rvalid), DW'(c_due));
      check("dma_rvalid", DW'(dma_rvalid), DW'(d_due));
      if (c_due) begin e_c = cpu_q.pop_front(); check("cpu_rdata", cpu_rdata, e_c.data); end
      if (d_due) begin e_d = dma_q.pop_front(); check("dma_rdata", dma_rdata, e_d.data); end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_cpu_gnt"},    DW'(cpu_gnt),    '0);
    check({tag, "_dma_gnt"},    DW'(dma_gnt),    '0);
    check({tag, "_stall_m"},    DW'(stall_m),    '0);
    check({tag, "_dma_busy"},   DW'(dma_busy),   '0);
    check({tag, "_cpu_rvalid"}, DW'(cpu_rvalid), '0);
    check({tag, "_dma_rvalid"}, DW'(dma_rvalid), '0);
    check({tag, "_cpu_rdata"},  cpu_rdata,       '0);
    check({tag, "_dma_rdata"},  dma_rdata,       '0);
    check({tag, "_mem_we"},     DW'(mem_we),     '0);
    check({tag, "_mem_addr"},   DW'(mem_addr),   '0);
  endtask

  initial begin
    logic g_c, g_d, busy, stall;
    logic [DW-1:0] a5;
    logic [DW-1:0] wd;
    bit            cpu_pend, c_we, dma_act, d_we, d_uselast;
    logic [AW-1:0] c_addr, d_addr;
    logic [DW-1:0] c_wd, d_wd;
    int            d_left, beats;

    // Reset state, with a backdoor preload of the A5 pattern at 0x0010.
    model_reset();
    a5 = {(DW / 8){8'hA5}};
    pre_addr = 10'h010; pre_data = a5; pre_we = 1'b1;
    ref_mem[16'h0010] = a5;
    @(posedge clk); #1 pre_we = 1'b0;
    #3 check_all_zero("reset");
    @(negedge clk) rst = 1'b1;

    // CPU read of 0x0010 returns the A5 pattern one cycle later.
    cycle(1, 0, 16'h0010, '0, 0, 0, '0, '0, 0, g_c, g_d, busy, stall);
    check("cpu_read_gnt", DW'(g_c), DW'(1));
    check("cpu_read_stall", DW'(stall), '0);
    idle_cycle();
    check("cpu_rdata_hold", cpu_rdata, a5);

    // Both requesting, DMA single beats: CPU x4 then DMA once, repeating.
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, 16'h0010, '0, 1, 1, 16'h0020, rand256(), 1, g_c, g_d, busy, stall);
      check("starve_dma_gnt", DW'(g_d), DW'(i % 5 == 4));
      check("starve_stall", DW'(stall), DW'(i % 5 == 4));
    end
    idle_cycle();

    // Five-beat DMA write burst to 0x0100..0x0104, then read it back.
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, '0, '0, 1, 1, AW'(16'h0100 + i), rand256(), i == 4, g_c, g_d, busy, stall);
      check("burst5_gnt", DW'(g_d), DW'(1));
      check("burst5_busy", DW'(busy), DW'(i != 0));
    end
    idle_cycle();
    for (int i = 0; i < 5; i++)
      cycle(0, 0, '0, '0, 1, 0, AW'(16'h0100 + i), '0, 1, g_c, g_d, busy, stall);
    idle_cycle();

    // Twelve beats with no dma_last: lock drops after beat 8, beat 9 relocks.
    for (int i = 0; i < 12; i++) begin
      cycle(0, 0, '0, '0, 1, 0, AW'(16'h0100 + i), '0, 0, g_c, g_d, busy, stall);
      check("burst12_busy", DW'(busy), DW'(i != 0 && i != 8));
    end
    idle_cycle();

    // CPU arrives at beat 2 of a long burst: 4 stalls, one stolen cycle,
    // and the burst count carries on so the lock still ends after beat 8.
    beats = 0; cpu_pend = 0;
    for (int j = 0; j < 11; j++) begin
      if (j == 1) cpu_pend = 1;
      cycle(cpu_pend, 0, 16'h0010, '0, 1, 0, AW'(16'h0200 + beats), '0, 0, g_c, g_d, busy, stall);
      check("steal_stall", DW'(stall), DW'(j >= 1 && j <= 4));
      check("steal_cpu_gnt", DW'(g_c), DW'(j == 5));
      check("steal_busy", DW'(busy), DW'((j >= 1 && j <= 8) || j == 10));
      if (m_cg) cpu_pend = 0;
      if (m_dg) beats++;
    end
    idle_cycle();

    // Reset asserted during beat 3 of a DMA write burst.
    for (int i = 0; i < 2; i++)
      cycle(0, 0, '0, '0, 1, 1, AW'(16'h0300 + i), rand256(), 0, g_c, g_d, busy, stall);
    @(posedge clk); #1;
    dma_addr = 16'h0302; dma_wdata = rand256();
    #1 rst = 1'b0;
    #2 check_all_zero("midburst_rst");
    model_reset();
    dma_req = 1'b0;
    @(negedge clk) rst = 1'b1;
    cycle(1, 0, 16'h0010, '0, 0, 0, '0, '0, 0, g_c, g_d, busy, stall);
    check("post_rst_cpu_gnt", DW'(g_c), DW'(1));
    idle_cycle();

    // Randomized traffic from both requesters.
    cpu_pend = 0; dma_act = 0; d_left = 0;
    c_we = 0; c_addr = '0; c_wd = '0; d_we = 0; d_uselast = 0; d_addr = '0; d_wd = '0;
    for (int k = 0; k < 2000; k++) begin
      if (!cpu_pend && $urandom_range(0, 99) < 40) begin
        cpu_pend = 1; c_we = 1'($urandom_range(0, 1));
        c_addr = AW'($urandom_range(0, 127)); c_wd = rand256();
      end
      if (!dma_act && $urandom_range(0, 99) < 15) begin
        dma_act = 1; d_left = $urandom_range(1, 12);
        d_uselast = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1));
        d_addr = AW'($urandom_range(0, 115)); d_wd = rand256();
      end
      cycle(cpu_pend, c_we, c_addr, c_wd, dma_act, d_we, d_addr, d_wd,
            dma_act && d_uselast && d_left == 1, g_c, g_d, busy, stall);
      if (m_cg) cpu_pend = 0;
      if (m_dg) begin
        d_left--;
        if (d_left == 0) dma_act = 0;
        else begin d_addr = d_addr + 1'b1; d_wd = rand256(); end
      end
    end
    idle_cycle();
    idle_cycle();

    check("cpu_q_drained", DW'(cpu_q.size()), '0);
    check("dma_q_drained", DW'(dma_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single Data_Memory port (WE/WD/A/RD, 256-bit data) between two requesters: the pipeline memory stage (CPU port) and a vector/FIR coefficient loader (DMA port).
- Grants one access per cycle. DMA may lock the port for bursts.
- Per-requester starvation counters bound the wait on both sides.
- Read data is registered and returned with a one-cycle valid pulse.
- Produces a stall request for the pipeline while the CPU port is denied.

Parameters:
DATA_W, 256, data width of memory and both ports
ADDR_W, 16, memory address width
MAX_BURST, 8, maximum DMA beats per locked burst (range 1..255)
STARVE_LIMIT, 4, consecutive denied cycles after which the waiting requester is forced a grant (range 1..255)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  asynchronous reset, active low
cpu_req  in  1  CPU access request, held until granted
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  combinational grant; access performed this cycle
cpu_rvalid  out  1  one-cycle pulse, cpu_rdata valid
cpu_rdata  out  DATA_W  registered read data
stall_m  out  1  cpu_req & ~cpu_gnt
dma_req  in  1  DMA access request
dma_we  in  1  1 = write
dma_addr  in  ADDR_W  DMA address
dma_wdata  in  DATA_W  DMA write data
dma_last  in  1  marks final beat of a burst
dma_gnt  out  1  combinational grant
dma_rvalid  out  1  one-cycle pulse
dma_rdata  out  DATA_W  registered read data
mem_we  out  1  to Data_Memory WE
mem_addr  out  ADDR_W  to Data_Memory A
mem_wd  out  DATA_W  to Data_Memory WD
mem_rd  in  DATA_W  from Data_Memory RD (combinational read)
dma_busy  out  1  high while in DMA_BURST state

Behaviour:
- Reset (rst=0, async): state=IDLE; burst_cnt, cpu_wait, dma_wait = 0; cpu_rdata and dma_rdata = 0; cpu_rvalid and dma_rvalid = 0.
- Grants are decoded combinationally from state, counters and requests. At most one grant is high per cycle. No grant is issued without the matching req.
- Memory mux:
  - cpu_gnt routes cpu_addr, cpu_wdata, cpu_we.
  - dma_gnt routes the DMA fields.
  - With no grant: mem_we=0, mem_addr=0, mem_wd=0.
- Write commits in the Data_Memory at the clock edge that ends the grant cycle.
- Read, cycle N grant with we=0:
  - mem_rd is captured into the owner's rdata at the end of cycle N.
  - The owner's rvalid is high for cycle N+1 only.
  - Writes produce no rvalid.
  - rdata holds its value until the next read to that port.
- IDLE arbitration:
  - CPU only: grant CPU.
  - DMA only: grant DMA.
  - Both: grant CPU, unless dma_wait==STARVE_LIMIT, in which case grant DMA.
  - On a DMA grant with dma_last=0 and MAX_BURST>1: go to DMA_BURST with burst_cnt=1.
- DMA_BURST (locked):
  - dma_req=1 is granted each cycle and burst_cnt increments.
  - Exception: if cpu_wait==STARVE_LIMIT, the CPU is granted that one cycle instead. The lock and burst_cnt are retained and the DMA is not granted.
  - Exit to IDLE after a granted DMA beat with dma_last=1, or after the granted beat that makes burst_cnt==MAX_BURST.
  - Exit to IDLE at once if dma_req=0 with no grant to DMA; that cycle is still arbitrated as in IDLE.
- Wait counters:
  - cpu_wait increments each cycle with cpu_req & ~cpu_gnt, saturating at STARVE_LIMIT. It clears on cpu_gnt or when cpu_req=0.
  - dma_wait follows the same rule for DMA.
- dma_last=1 on a beat granted in IDLE: single-beat access, state stays IDLE.
- Reset mid-burst: state returns to IDLE and counters clear. A write in the cycle where rst falls is not guaranteed to commit. Any pending rvalid is dropped.
- Requests and payload may change only after the grant cycle. The arbiter does not latch request payloads.

Test Plan:
- Reset, then CPU read addr 0x0010 with mem_rd=0xA5..A5 → cpu_gnt same cycle, cpu_rvalid one cycle later with cpu_rdata=0xA5..A5; stall_m=0 throughout.
- CPU and DMA both request continuously from IDLE, DMA single beats (dma_last=1), STARVE_LIMIT=4 → CPU granted for 4 cycles, DMA granted on the 5th, pattern repeats. stall_m is high only on the DMA-granted cycles.
- DMA write burst of 5 beats, addrs 0x0100..0x0104, dma_last on beat 5, no CPU traffic → dma_gnt for 5 consecutive cycles, dma_busy high from beat 2 through beat 5, IDLE afterwards, memory holds all 5 words.
- DMA burst of 12 beats without dma_last, MAX_BURST=8 → lock released after beat 8. Beat 9 is re-arbitrated from IDLE and re-enters DMA_BURST.
- CPU requests at burst beat 2 of a long DMA burst, STARVE_LIMIT=4 → stall_m high for 4 cycles, then CPU granted one cycle. The DMA resumes next cycle with burst_cnt continuing, not reset.
- rst asserted low during beat 3 of a DMA burst → all outputs zero immediately. After release, a CPU request is granted in the first cycle.
